vga_source_sched: RTL and testbench

- Frame-synchronous scheduler that shares the single vga2hdmi_sdr encoder between two VGA sources, e.g. the caleidoscope generator and the DVI test-picture generator.
- Sits between the generators and vga2hdmi_sdr, in the clk_pixel domain.
- A debounced button requests a source swap. The swap happens only at a vsync assertion edge, followed by a colour-muted settle period so the sink relocks cleanly.
- A vsync watchdog forces the swap if the current source has stalled.

---
 rtl/vga_source_sched_pkg.sv | 19 +
 rtl/vga_source_sched_btn_debounce.sv | 40 ++++
 rtl/vga_source_sched.sv | 151 +++++++++++++++
 tb/tb_vga_source_sched.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_source_sched_pkg.sv
// Shared types and reset constants for the VGA source scheduler.
package vga_source_sched_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    WAIT_VS = 2'd1,
    MUTE    = 2'd2
  } state_t;

  // Idle values of the output video bundle (colour resets to '0).
  localparam logic RST_HSYNC = 1'b0;
  localparam logic RST_BLANK = 1'b1;

  // vsync idles at its inactive level.
  function automatic logic rst_vsync(input logic vsync_active);
    return ~vsync_active;
  endfunction

endpackage

// File: rtl/vga_source_sched_btn_debounce.sv
// Button synchroniser and stability debouncer.
module btn_debounce #(
  parameter int unsigned C_bits = 16
) (
  input  logic clk_pixel,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_rise
);

  logic              sync1;
  logic              sync2;
  logic [C_bits-1:0] cnt;

  // Two-flop synchroniser, then accept a new level only after 2**C_bits differing cycles.
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      cnt       <= '0;
      btn_level <= 1'b0;
      btn_rise  <= 1'b0;
    end else begin
      sync1    <= btn_raw;
      sync2    <= sync1;
      btn_rise <= 1'b0;
      if (sync2 == btn_level) begin
        cnt <= '0;
      end else if (cnt == '1) begin
        cnt       <= '0;
        btn_level <= sync2;
        btn_rise  <= sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/vga_source_sched.sv
// Frame-synchronous switch between two VGA sources feeding one HDMI encoder.
module vga_source_sched
  import vga_source_sched_pkg::*;
#(
  parameter int unsigned C_depth         = 3,
  parameter int unsigned C_debounce_bits = 16,
  parameter int unsigned C_mute_frames   = 2,
  parameter int unsigned C_watchdog_bits = 20,
  parameter logic        C_vsync_active  = 1'b1
) (
  input  logic               clk_pixel,
  input  logic               reset,
  input  logic               btn,
  input  logic [C_depth-1:0] src0_r,
  input  logic [C_depth-1:0] src0_g,
  input  logic [C_depth-1:0] src0_b,
  input  logic               src0_hsync,
  input  logic               src0_vsync,
  input  logic               src0_blank,
  input  logic [C_depth-1:0] src1_r,
  input  logic [C_depth-1:0] src1_g,
  input  logic [C_depth-1:0] src1_b,
  input  logic               src1_hsync,
  input  logic               src1_vsync,
  input  logic               src1_blank,
  output logic [C_depth-1:0] out_r,
  output logic [C_depth-1:0] out_g,
  output logic [C_depth-1:0] out_b,
  output logic               out_hsync,
  output logic               out_vsync,
  output logic               out_blank,
  output logic               active_src,
  output logic               muting,
  output logic               vsync_lost
);

  localparam int unsigned MW = (C_mute_frames > 2) ? $clog2(C_mute_frames) : 1;

  logic                       btn_level;
  logic                       btn_rise;
  state_t                     state, state_next;
  logic                       pending, pend_next;
  logic                       sel_next;
  logic                       swap;
  logic                       vs_prev;
  logic                       sel_vsync;
  logic                       vs_edge;
  logic [MW-1:0]              mute_cnt, mute_next;
  logic [C_watchdog_bits-1:0] wd_cnt, wd_next;
  logic [C_depth-1:0]         nxt_r, nxt_g, nxt_b;
  logic                       nxt_hsync, nxt_vsync, nxt_blank;

  btn_debounce #(.C_bits(C_debounce_bits)) u_debounce (
    .clk_pixel (clk_pixel),
    .reset     (reset),
    .btn_raw   (btn),
    .btn_level (btn_level),
    .btn_rise  (btn_rise)
  );

  // Edge detect on the currently selected source's vsync.
  always_comb begin
    sel_vsync = active_src ? src1_vsync : src0_vsync;
    vs_edge   = (sel_vsync == C_vsync_active) && (vs_prev != C_vsync_active);
  end

  // Next state, selection, pending request, mute and watchdog counters.
  always_comb begin
    state_next = state;
    sel_next   = active_src;
    mute_next  = mute_cnt;
    swap       = 1'b0;
    pend_next  = pending | (btn_rise & btn_level);
    unique case (state)
      RUN: begin
        if (pending) begin
          state_next = WAIT_VS;
          pend_next  = btn_rise & btn_level;
        end
      end
      WAIT_VS: begin
        if (vs_edge || vsync_lost) begin
          swap       = 1'b1;
          sel_next   = ~active_src;
          mute_next  = '0;
          state_next = (C_mute_frames == 0) ? RUN : MUTE;
        end
      end
      MUTE: begin
        if (vsync_lost) begin
          state_next = RUN;
        end else if (vs_edge) begin
          if (int'(mute_cnt) == int'(C_mute_frames) - 1) state_next = RUN;
          else mute_next = mute_cnt + 1'b1;
        end
      end
      default: state_next = RUN;
    endcase

    if (vs_edge || swap) wd_next = '0;
    else if (wd_cnt == '1) wd_next = wd_cnt;
    else wd_next = wd_cnt + 1'b1;
  end

  // Source mux driven by the next selection so a swap switches every output bit at once.
  always_comb begin
    nxt_r     = sel_next ? src1_r     : src0_r;
    nxt_g     = sel_next ? src1_g     : src0_g;
    nxt_b     = sel_next ? src1_b     : src0_b;
    nxt_hsync = sel_next ? src1_hsync : src0_hsync;
    nxt_vsync = sel_next ? src1_vsync : src0_vsync;
    nxt_blank = sel_next ? src1_blank : src0_blank;
  end

  // Registered FSM, counters and output video bundle.
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      state      <= RUN;
      pending    <= 1'b0;
      active_src <= 1'b0;
      mute_cnt   <= '0;
      wd_cnt     <= '0;
      vsync_lost <= 1'b0;
      muting     <= 1'b0;
      vs_prev    <= C_vsync_active;
      out_r      <= '0;
      out_g      <= '0;
      out_b      <= '0;
      out_hsync  <= RST_HSYNC;
      out_vsync  <= rst_vsync(C_vsync_active);
      out_blank  <= RST_BLANK;
    end else begin
      state      <= state_next;
      pending    <= pend_next;
      active_src <= sel_next;
      mute_cnt   <= mute_next;
      wd_cnt     <= wd_next;
      vsync_lost <= (wd_next == '1);
      muting     <= (state_next == MUTE);
      // nxt_vsync is the new source on a swap, so the edge history never mixes sources.
      vs_prev    <= nxt_vsync;
      out_r      <= (state_next == MUTE) ? '0 : nxt_r;
      out_g      <= (state_next == MUTE) ? '0 : nxt_g;
      out_b      <= (state_next == MUTE) ? '0 : nxt_b;
      out_hsync  <= nxt_hsync;
      out_vsync  <= nxt_vsync;
      out_blank  <= nxt_blank;
    end
  end

endmodule

// File: tb/tb_vga_source_sched.sv
// Directed bench for vga_source_sched: reset, debounce, swap timing, double press, stall, reset mid-mute.
module tb_vga_source_sched;
  import vga_source_sched_pkg::*;

  logic       clk_pixel = 1'b0;
  logic       reset = 1'b1;
  logic       btn = 1'b0;
  logic [2:0] src0_r, src0_g, src0_b, src1_r, src1_g, src1_b;
  logic       src0_hsync, src0_vsync, src0_blank;
  logic       src1_hsync, src1_vsync, src1_blank;
  logic [2:0] out_r, out_g, out_b;
  logic       out_hsync, out_vsync, out_blank;
  logic       active_src, muting, vsync_lost;

  int   tests = 0;
  int   fails = 0;
  int   swaps = 0;
  int   base;
  int   k;
  int   c0 = 0;
  int   c1 = 50;
  logic stall0 = 1'b0;
  logic pv0 = 1'b0, pv1 = 1'b0;
  logic act_q = 1'b0;

  vga_source_sched #(
    .C_depth(3), .C_debounce_bits(4), .C_mute_frames(2),
    .C_watchdog_bits(8), .C_vsync_active(1'b1)
  ) dut (
    .clk_pixel(clk_pixel), .reset(reset), .btn(btn),
    .src0_r(src0_r), .src0_g(src0_g), .src0_b(src0_b),
    .src0_hsync(src0_hsync), .src0_vsync(src0_vsync), .src0_blank(src0_blank),
    .src1_r(src1_r), .src1_g(src1_g), .src1_b(src1_b),
    .src1_hsync(src1_hsync), .src1_vsync(src1_vsync), .src1_blank(src1_blank),
    .out_r(out_r), .out_g(out_g), .out_b(out_b),
    .out_hsync(out_hsync), .out_vsync(out_vsync), .out_blank(out_blank),
    .active_src(active_src), .muting(muting), .vsync_lost(vsync_lost)
  );

  always #5 clk_pixel = ~clk_pixel;

  task automatic drive_src();
    src0_r     = 3'(c0 % 8);
    src0_g     = 3'((c0 / 8) % 8);
    src0_b     = 3'(7 - (c0 % 8));
    src0_hsync = (c0 % 10) < 2;
    src0_vsync = (c0 < 3) && !stall0;
    src0_blank = (c0 >= 90) || (c0 < 5);
    src1_r     = 3'((c1 + 3) % 8);
    src1_g     = 3'((c1 / 4) % 8);
    src1_b     = 3'((c1 % 5) + 2);
    src1_hsync = (c1 % 10) >= 7;
    src1_vsync = (c1 < 3);
    src1_blank = (c1 >= 85) || (c1 < 4);
  endtask

  // Two free-running frame generators (100-cycle frames, 3-cycle vsync), updated mid-cycle.
  initial begin
    drive_src();
    forever begin
      @(negedge clk_pixel);
      c0 = (c0 + 1) % 100;
      c1 = (c1 + 1) % 100;
      drive_src();
    end
  end

  // Count every change of the selected source.
  always @(negedge clk_pixel) begin
    if (active_src !== act_q) swaps++;
    act_q = active_src;
  end

  task automatic tick();
    pv0 = src0_vsync;
    pv1 = src1_vsync;
    @(posedge clk_pixel);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_vid(input string tag, input logic s, input logic muted);
    logic [11:0] e;
    e[11:9] = muted ? 3'd0 : (s ? src1_r : src0_r);
    e[8:6]  = muted ? 3'd0 : (s ? src1_g : src0_g);
    e[5:3]  = muted ? 3'd0 : (s ? src1_b : src0_b);
    e[2]    = s ? src1_hsync : src0_hsync;
    e[1]    = s ? src1_vsync : src0_vsync;
    e[0]    = s ? src1_blank : src0_blank;
    check(tag, {out_r, out_g, out_b, out_hsync, out_vsync, out_blank}, e);
  endtask

  task automatic press();
    btn = 1'b1;
    repeat (20) tick();
    btn = 1'b0;
  endtask

  // Wait for a swap to source `to`; it must land on the old source's vsync rise.
  task automatic wait_swap(input logic to, input string tag);
    int n = 0;
    while (active_src !== to && n < 300) begin
      tick();
      n++;
    end
    check({tag, "_done"}, active_src, to);
    check({tag, "_on_vs_rise"}, to ? {pv0, src0_vsync} : {pv1, src1_vsync}, 2'b01);
    check({tag, "_muting"}, muting, 1'b1);
    check_vid({tag, "_vid"}, to, 1'b1);
  endtask

  // Follow a mute to its end: colour zero, syncs from s, ends on the 2nd vsync rise of s.
  task automatic run_mute(input logic s, input string tag);
    int rises = 0;
    int n = 0;
    do begin
      tick();
      n++;
      if (s ? (src1_vsync && !pv1) : (src0_vsync && !pv0)) rises++;
      if (muting === 1'b1) check_vid({tag, "_muted"}, s, 1'b1);
    end while (muting === 1'b1 && n < 400);
    check({tag, "_edges"}, rises, 2);
    check_vid({tag, "_end_vid"}, s, 1'b0);
    check({tag, "_end_src"}, active_src, s);
  endtask

  task automatic wait_mute_end();
    int n = 0;
    while (muting === 1'b1 && n < 400) begin
      tick();
      n++;
    end
  endtask

  initial begin
    // Reset while sources are active.
    reset = 1'b1;
    repeat (3) tick();
    check("rst_video", {out_r, out_g, out_b, out_hsync, out_vsync, out_blank}, 12'h001);
    check("rst_active_src", active_src, 1'b0);
    check("rst_muting", muting, 1'b0);
    check("rst_vsync_lost", vsync_lost, 1'b0);
    reset = 1'b0;
    tick();
    check_vid("src0_latency1", 1'b0, 1'b0);
    tick();
    check_vid("src0_latency1_b", 1'b0, 1'b0);

    // Bouncy button: never stable long enough.
    base = swaps;
    for (int i = 0; i < 12; i++) begin
      btn = ~btn;
      repeat (5) tick();
    end
    btn = 1'b0;
    repeat (150) tick();
    check("bounce_no_swap", swaps - base, 0);
    check("bounce_src", active_src, 1'b0);

    // Stable press: one swap to src1 at the src0 vsync rise, two-frame mute.
    press();
    wait_swap(1'b1, "swap1");
    run_mute(1'b1, "mute1");
    repeat (50) tick();
    check("press_one_swap", swaps - base, 1);

    // Double press: second press during mute is serviced after return to RUN.
    base = swaps;
    press();
    wait_swap(1'b0, "swap2");
    repeat (25) tick();
    press();
    check("dbl_still_muting", muting, 1'b1);
    wait_mute_end();
    check("dbl_mute_end_src", active_src, 1'b0);
    wait_swap(1'b1, "swap3");
    run_mute(1'b1, "mute3");
    repeat (150) tick();
    check("dbl_two_swaps", swaps - base, 2);

    // Reset in the middle of a mute.
    press();
    wait_swap(1'b0, "swap4");
    repeat (30) tick();
    check("pre_rst_muting", muting, 1'b1);
    reset = 1'b1;
    tick();
    check("midrst_active_src", active_src, 1'b0);
    check("midrst_muting", muting, 1'b0);
    check("midrst_state", dut.state, RUN);
    check("midrst_video", {out_r, out_g, out_b, out_hsync, out_vsync, out_blank}, 12'h001);
    reset = 1'b0;
    tick();
    check_vid("postrst_vid", 1'b0, 1'b0);
    base = swaps;
    repeat (150) tick();
    check("postrst_no_swap", swaps - base, 0);

    // Stall: src0 vsync stops right after a rise; watchdog forces the swap.
    k = 0;
    while (!(src0_vsync && !pv0) && k < 200) begin
      tick();
      k++;
    end
    check("stall_sync_rise", {pv0, src0_vsync}, 2'b01);
    stall0 = 1'b1;
    k = 0;
    btn = 1'b1;
    repeat (20) begin
      tick();
      k++;
    end
    btn = 1'b0;
    while (vsync_lost !== 1'b1 && k < 400) begin
      tick();
      k++;
    end
    check("stall_lost_cycles", k, 255);
    check("stall_src_before", active_src, 1'b0);
    tick();
    check("stall_swap", active_src, 1'b1);
    check("stall_lost_cleared", vsync_lost, 1'b0);
    check("stall_muting", muting, 1'b1);
    stall0 = 1'b0;
    run_mute(1'b1, "mute_stall");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
